sram_port0_arbiter: RTL
=======================

# sram_port0_arbiter

Sequencer and arbiter for port 0 (read/write port) of the 1 KB sky130 SRAM that holds the calculator microcode. Two requesters share the port: the management SoC over Wishbone, and a toggle-handshake requester driven from logic-analyzer bits. The block generates the SRAM `clk0`/`csb0`/`web0` waveform itself from `wb_clk_i`, arbitrates round-robin, and returns read data to whichever requester was granted. Port 1 (the core's read port) is untouched.

## Interface
- `BASE_ADDR`, default 8'h30: Wishbone hit when `wbs_adr_i[31:24] == BASE_ADDR`.
- `wb_clk_i` in 1: sole clock.
- `wb_rst_ni` in 1: **asynchronous, active-low** reset.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1 each: Wishbone classic request.
- `wbs_sel_i` in 4: byte enables, map to `sram_wmask0`.
- `wbs_adr_i` in 32: byte address; word address is `[9:2]`.
- `wbs_dat_i` in 32: write data.
- `wbs_ack_o` out 1: one-cycle acknowledge, hits only.
- `wbs_dat_o` out 32: read data, valid while `wbs_ack_o` is high, otherwise 0.
- `la_req_i` in 1: LA request toggle.
- `la_we_i` in 1: LA write enable.
- `la_addr_i` in 8: LA word address.
- `la_din_i` in 32: LA write data, full-word mask.
- `la_ack_o` out 1: LA done toggle. A request is pending while `la_req_i != la_ack_o`.
- `la_dout_o` out 32: last LA read data, held until the next LA read completes.
- `sram_clk0`, `sram_csb0`, `sram_web0` out 1 each: SRAM port-0 controls.
- `sram_addr0` out 8, `sram_wmask0` out 4, `sram_din0` out 32: SRAM port-0 address, mask and data.
- `sram_dout0` in 32: SRAM port-0 read data.

## Operation
- FSM states: IDLE → SETUP → EDGE → HOLD → DONE → IDLE.
- **IDLE**
  - `wb_pend = cyc & stb & hit`; `la_pend = la_req_i ^ la_ack_o`.
  - If either is pending: register grant, address, data, we and mask, then go to SETUP.
- **SETUP**: `csb0=0`, `web0=~we`, `clk0=0`. Address, data and mask are stable.
- **EDGE**: `clk0=1`. The SRAM samples here.
- **HOLD**: `clk0=0`. At the end of HOLD, `sram_dout0` is captured into the read register (reads only).
- **DONE**
  - `csb0=1`.
  - WB grant: `wbs_ack_o=1` for exactly this cycle; `wbs_dat_o` = captured word (0 on a write).
  - LA grant: `la_ack_o` toggles; `la_dout_o` updates on a read.
- **Arbitration**
  - Round-robin on `last_grant`. Reset value is LA, so WB wins the first tie.
  - When only one requester is pending, it is granted regardless of `last_grant`.
- **Masks**: WB uses `wbs_sel_i`; LA always uses 4'b1111. Reads drive `web0=1`; the mask is don't-care.
- **Non-hits**: WB cycles outside `BASE_ADDR` are ignored and never acked. `wbs_adr_i[23:10]` is ignored (aliasing is accepted).
- **Register outputs**: all SRAM outputs come from flops, so `clk0` is glitch-free.

## Timing
- **Reset values**: state IDLE, `sram_clk0=0`, `sram_csb0=1`, `sram_web0=1`, `sram_addr0=0`, `sram_wmask0=0`, `sram_din0=0`, `wbs_ack_o=0`, `wbs_dat_o=0`, `la_ack_o=0`, `la_dout_o=0`, `last_grant=LA`.
- **Latency**: request sampled in IDLE at cycle N; SETUP N+1, EDGE N+2, HOLD N+3, ack/toggle N+4; back in IDLE at N+5. Throughput is one access per 5 cycles.
- **WB master**: must hold `stb` until ack and drop it in cycle N+5. The IDLE state in N+5 therefore sees no WB request.
- **WB abort**: if `cyc`/`stb` drop after grant, the access still completes on the SRAM, and the ack is suppressed.
- **LA toggle during an access**: a toggle of `la_req_i` while the LA access is in flight is still seen as pending after DONE, and is serviced as a new request.
- **Simultaneous pending**: alternates WB, LA, WB, … with no idle gap beyond IDLE.
- **Reset mid-access**: outputs return immediately to reset values; the in-flight access is dropped and no ack is generated.

## Structure
- Shared package `sram_arb_pkg`:
  - state enum `arb_state_t` (IDLE, SETUP, EDGE, HOLD, DONE);
  - `SRAM_AW=8`, `SRAM_DW=32`, `SRAM_MW=4`;
  - grant constants `GNT_WB`, `GNT_LA`.
- One sub-module, `rr_arb2`: 2-requester round-robin with a `last_grant` flop, updated only when IDLE accepts a request.

## Test plan
- **WB write then read**: WB write 0xDEADBEEF to 0x3000_0010, sel 4'hF; then WB read of the same address → `sram_addr0=8'h04`, exactly one `clk0` pulse per access, ack at N+4, `wbs_dat_o=0xDEADBEEF`.
- **Byte-masked write**: WB write with sel 4'b0011 → `sram_wmask0=4'b0011` during SETUP–HOLD; a readback shows only the low half updated.
- **LA write then read**: toggle `la_req_i` with write of 0x0000_1234 to addr 8'hFF; then toggle again with a read → `la_ack_o` toggles twice, `la_dout_o=0x0000_1234`, `wbs_ack_o` never asserted.
- **Simultaneous requests**: WB and LA both pending out of reset → WB granted first, LA second; two back-to-back WB+LA pairs alternate grants.
- **Non-hit address**: WB to 0x2000_0000 → SRAM `csb0` stays 1, no ack.
- **Reset mid-access**: assert `wb_rst_ni` low during EDGE → `clk0=0`, `csb0=1` immediately; no ack; after release, a new WB read completes normally.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared definitions for the port-0 SRAM sequencer/arbiter.
//   arb_state_t : access sequencer states (idle, setup, clock edge, hold, done)
//   SRAM_*      : port-0 address, data and write-mask widths
//   GNT_*       : grant encodings for the two requesters
package sram_arb_pkg;

    localparam int unsigned SRAM_AW = 8;
    localparam int unsigned SRAM_DW = 32;
    localparam int unsigned SRAM_MW = 4;

    localparam logic GNT_WB = 1'b0;
    localparam logic GNT_LA = 1'b1;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StSetup = 3'd1,
        StEdge  = 3'd2,
        StHold  = 3'd3,
        StDone  = 3'd4
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req_wb_i      : Wishbone request pending
//   req_la_i      : logic-analyzer request pending
//   accept_i      : the sequencer is idle and will take the current grant
//   gnt_o         : GNT_WB or GNT_LA (meaningful only while valid_o is high)
//   valid_o       : at least one request pending
module rr_arb2
    import sram_arb_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_wb_i,
    input  logic req_la_i,
    input  logic accept_i,
    output logic gnt_o,
    output logic valid_o
);

    logic last_q, last_d;

    always_comb begin
        valid_o = req_wb_i | req_la_i;
        if (req_wb_i && req_la_i) begin
            // Tie: whoever was not served last goes next.
            gnt_o = (last_q == GNT_LA) ? GNT_WB : GNT_LA;
        end else if (req_wb_i) begin
            gnt_o = GNT_WB;
        end else begin
            gnt_o = GNT_LA;
        end

        last_d = last_q;
        if (accept_i && valid_o) begin
            last_d = gnt_o;
        end
    end

    // Reset to LA so that Wishbone wins the first tie.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= GNT_LA;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/sram_port0_arbiter.sv
// Port-0 sequencer and arbiter for the microcode SRAM.
// Two requesters (Wishbone slave, LA toggle handshake) share the read/write port.
// Each access runs IDLE -> SETUP -> EDGE -> HOLD -> DONE; the SRAM clock pulse is
// generated from wb_clk_i and every SRAM control comes straight from a flop.
//   wb_clk_i, wb_rst_ni        : clock, asynchronous active-low reset
//   wbs_*                      : Wishbone classic slave (hit on adr[31:24] == BASE_ADDR)
//   la_req_i/la_ack_o          : toggle handshake; pending while they differ
//   la_we_i/la_addr_i/la_din_i : LA access command (full-word writes)
//   la_dout_o                  : last LA read word, held until the next LA read
//   sram_*0                    : SRAM port-0 pins
module sram_port0_arbiter
    import sram_arb_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'h30
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    input  logic               wbs_cyc_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    input  logic               la_req_i,
    input  logic               la_we_i,
    input  logic [SRAM_AW-1:0] la_addr_i,
    input  logic [SRAM_DW-1:0] la_din_i,
    output logic               la_ack_o,
    output logic [SRAM_DW-1:0] la_dout_o,
    output logic               sram_clk0,
    output logic               sram_csb0,
    output logic               sram_web0,
    output logic [SRAM_AW-1:0] sram_addr0,
    output logic [SRAM_MW-1:0] sram_wmask0,
    output logic [SRAM_DW-1:0] sram_din0,
    input  logic [SRAM_DW-1:0] sram_dout0
);

    arb_state_t         state_q, state_d;
    logic               gnt_q, gnt_d;
    logic               wb_live_q, wb_live_d;
    logic               clk0_q, clk0_d;
    logic               csb0_q, csb0_d;
    logic               web0_q, web0_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic [SRAM_MW-1:0] wmask_q, wmask_d;
    logic [SRAM_DW-1:0] din_q, din_d;
    logic               wbs_ack_q, wbs_ack_d;
    logic [31:0]        wbs_dat_q, wbs_dat_d;
    logic               la_ack_q, la_ack_d;
    logic [SRAM_DW-1:0] la_dout_q, la_dout_d;

    logic wb_hit, wb_pend, la_pend;
    logic arb_gnt, arb_valid, arb_accept;

    // Address bits outside the hit field and word index are aliased by design.
    logic unused_adr;
    assign unused_adr = ^{wbs_adr_i[23:10], wbs_adr_i[1:0]};

    assign wb_hit     = (wbs_adr_i[31:24] == BASE_ADDR);
    assign wb_pend    = wbs_cyc_i & wbs_stb_i & wb_hit;
    assign la_pend    = la_req_i ^ la_ack_q;
    assign arb_accept = (state_q == StIdle);

    rr_arb2 u_rr_arb2 (
        .clk_i    (wb_clk_i),
        .rst_ni   (wb_rst_ni),
        .req_wb_i (wb_pend),
        .req_la_i (la_pend),
        .accept_i (arb_accept),
        .gnt_o    (arb_gnt),
        .valid_o  (arb_valid)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        clk0_d    = clk0_q;
        csb0_d    = csb0_q;
        web0_d    = web0_q;
        addr_d    = addr_q;
        wmask_d   = wmask_q;
        din_d     = din_q;
        wbs_ack_d = wbs_ack_q;
        wbs_dat_d = wbs_dat_q;
        la_ack_d  = la_ack_q;
        la_dout_d = la_dout_q;
        // Once the master drops cyc/stb mid-access the ack is lost for good.
        wb_live_d = wb_live_q & wbs_cyc_i & wbs_stb_i;

        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    state_d = StSetup;
                    gnt_d   = arb_gnt;
                    csb0_d  = 1'b0;
                    clk0_d  = 1'b0;
                    if (arb_gnt == GNT_WB) begin
                        wb_live_d = 1'b1;
                        web0_d    = ~wbs_we_i;
                        addr_d    = wbs_adr_i[9:2];
                        din_d     = wbs_dat_i;
                        wmask_d   = wbs_we_i ? wbs_sel_i : '0;
                    end else begin
                        wb_live_d = 1'b0;
                        web0_d    = ~la_we_i;
                        addr_d    = la_addr_i;
                        din_d     = la_din_i;
                        wmask_d   = la_we_i ? {SRAM_MW{1'b1}} : '0;
                    end
                end
            end
            StSetup: begin
                state_d = StEdge;
                clk0_d  = 1'b1;
            end
            StEdge: begin
                state_d = StHold;
                clk0_d  = 1'b0;
            end
            StHold: begin
                state_d = StDone;
                csb0_d  = 1'b1;
                web0_d  = 1'b1;
                // web0_q still reflects this access here: 1 means read.
                if (gnt_q == GNT_WB) begin
                    if (wb_live_d) begin
                        wbs_ack_d = 1'b1;
                        wbs_dat_d = web0_q ? sram_dout0 : '0;
                    end
                end else begin
                    la_ack_d = ~la_ack_q;
                    if (web0_q) begin
                        la_dout_d = sram_dout0;
                    end
                end
            end
            StDone: begin
                state_d   = StIdle;
                wbs_ack_d = 1'b0;
                wbs_dat_d = '0;
                wb_live_d = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= StIdle;
            gnt_q     <= GNT_LA;
            wb_live_q <= 1'b0;
            clk0_q    <= 1'b0;
            csb0_q    <= 1'b1;
            web0_q    <= 1'b1;
            addr_q    <= '0;
            wmask_q   <= '0;
            din_q     <= '0;
            wbs_ack_q <= 1'b0;
            wbs_dat_q <= '0;
            la_ack_q  <= 1'b0;
            la_dout_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            wb_live_q <= wb_live_d;
            clk0_q    <= clk0_d;
            csb0_q    <= csb0_d;
            web0_q    <= web0_d;
            addr_q    <= addr_d;
            wmask_q   <= wmask_d;
            din_q     <= din_d;
            wbs_ack_q <= wbs_ack_d;
            wbs_dat_q <= wbs_dat_d;
            la_ack_q  <= la_ack_d;
            la_dout_q <= la_dout_d;
        end
    end

    assign sram_clk0   = clk0_q;
    assign sram_csb0   = csb0_q;
    assign sram_web0   = web0_q;
    assign sram_addr0  = addr_q;
    assign sram_wmask0 = wmask_q;
    assign sram_din0   = din_q;
    assign wbs_ack_o   = wbs_ack_q;
    assign wbs_dat_o   = wbs_dat_q;
    assign la_ack_o    = la_ack_q;
    assign la_dout_o   = la_dout_q;

endmodule
